// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // Supervisor sequencing states.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } pll_state_t;

  // Retry counter saturates here; the status word only carries 4 bits.
  localparam int RETRY_MAX = 15;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0 .. span-1; never less than one bit.
  function automatic int cnt_width(input int span);
    return (span <= 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser with synchronous active-low clear.
// Also used by the downstream domains to re-time their local resets.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain; clear to 0 on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds the PLL in reset, waits for a stable lock,
// then releases the 96 MHz and 48 MHz domain resets in two stages.
// Retries the PLL reset on lock timeout and reports retry / lock-loss status.
//
// Timing model: every output is a register loaded from the next state, so
// the outputs always describe the state the FSM is in during that cycle.
// Only the synchronised lock (locked_s) is ever used for decisions.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int STABLE_CYCLES  = 4096,
  parameter int STAGE_GAP      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       rst_fast_n,
  output logic       rst_core_n,
  output logic [3:0] retries,
  output logic       lock_lost,
  output logic       running,
  output logic [2:0] state_o
);

  // One counter serves every timed state, so it is sized for the longest span.
  localparam int MAX_SPAN = max2(max2(LOCK_TIMEOUT, STABLE_CYCLES),
                                 max2(PLL_RST_CYCLES, STAGE_GAP));
  localparam int CNT_W    = cnt_width(MAX_SPAN);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [3:0]       RETRY_SAT    = 4'(RETRY_MAX);

  logic             locked_s;

  pll_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d;
  logic             lock_lost_q, lock_lost_d;

  logic             pll_rst_q, pll_rst_d;
  logic             rst_fast_n_q, rst_fast_n_d;
  logic             rst_core_n_q, rst_core_n_d;
  logic             running_q, running_d;

  // Bring the asynchronous PLL lock into the clk domain.
  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // State, counter, status and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      retries_q    <= '0;
      lock_lost_q  <= 1'b0;
      pll_rst_q    <= 1'b1;
      rst_fast_n_q <= 1'b0;
      rst_core_n_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      lock_lost_q  <= lock_lost_d;
      pll_rst_q    <= pll_rst_d;
      rst_fast_n_q <= rst_fast_n_d;
      rst_core_n_q <= rst_core_n_d;
      running_q    <= running_d;
    end
  end

  // Next-state logic. Lock loss outranks soft reset; a lock arriving on the
  // timeout cycle outranks the retry. The counter restarts on every change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retries_d   = retries_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          if (retries_q != RETRY_SAT) begin
            retries_d = retries_q + 4'd1;
          end
        end
      end

      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end

      RELEASE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_rst_req) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end

      RUN: begin
        // Nothing is timed in RUN; park the counter so it cannot wrap.
        cnt_d = '0;
        if (!locked_s) begin
          state_d     = WAIT_LOCK;
          lock_lost_d = 1'b1;
        end else if (soft_rst_req) begin
          state_d = STABLE;
        end
      end

      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    pll_rst_d    = (state_d == PLL_RST);
    rst_fast_n_d = (state_d == RELEASE) || (state_d == RUN);
    rst_core_n_d = (state_d == RUN);
    running_d    = (state_d == RUN);
  end

  assign pll_rst    = pll_rst_q;
  assign rst_fast_n = rst_fast_n_q;
  assign rst_core_n = rst_core_n_q;
  assign retries    = retries_q;
  assign lock_lost  = lock_lost_q;
  assign running    = running_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: a table of hand-derived vectors, a few
// hand-written multi-cycle sequences, then randomized stimulus, all checked
// each cycle against a phase/age reference model.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int SS  = 2;
  localparam int PRC = 4;
  localparam int LT  = 32;
  localparam int SC  = 8;
  localparam int GAP = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n, pll_locked, soft_rst_req;
  logic       pll_rst, rst_fast_n, rst_core_n, lock_lost, running;
  logic [3:0] retries;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .SYNC_STAGES    (SS),
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .STAGE_GAP      (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .rst_fast_n   (rst_fast_n),
    .rst_core_n   (rst_core_n),
    .retries      (retries),
    .lock_lost    (lock_lost),
    .running      (running),
    .state_o      (state_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  // Phase plus "cycles already spent in phase"; locked_s is the raw input
  // delayed by SS sampled edges, held in a queue.
  pll_state_t m_phase;
  int         m_age;
  int         m_ret;
  logic       m_lost;
  logic       m_hist[$];

  task automatic model_reset_hist();
    m_hist.delete();
    for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step(input logic r, input logic l, input logic s);
    logic       ls;
    pll_state_t nxt;
    bit         restart;
    ls = m_hist[0];
    m_hist.push_back(l);
    void'(m_hist.pop_front());
    if (!r) begin
      m_phase = PLL_RST;
      m_age   = 0;
      m_ret   = 0;
      m_lost  = 1'b0;
      model_reset_hist();
      return;
    end
    nxt     = m_phase;
    restart = 1'b0;
    case (m_phase)
      PLL_RST:   if (m_age + 1 == PRC) nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (ls) nxt = STABLE;
        else if (m_age + 1 == LT) begin
          nxt = PLL_RST;
          if (m_ret < RETRY_MAX) m_ret = m_ret + 1;
        end
      end
      default: begin
        if (!ls) begin
          if (m_phase == RUN) m_lost = 1'b1;
          nxt = WAIT_LOCK;
        end else if (s) begin
          nxt     = STABLE;
          restart = 1'b1;
        end else if (m_phase == STABLE && m_age + 1 == SC) nxt = RELEASE;
        else if (m_phase == RELEASE && m_age + 1 == GAP) nxt = RUN;
      end
    endcase
    m_age   = (nxt != m_phase || restart) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    check("model.pll_rst",    8'(pll_rst),    8'(m_phase == PLL_RST));
    check("model.rst_fast_n", 8'(rst_fast_n), 8'(m_phase == RELEASE || m_phase == RUN));
    check("model.rst_core_n", 8'(rst_core_n), 8'(m_phase == RUN));
    check("model.running",    8'(running),    8'(m_phase == RUN));
    check("model.retries",    8'(retries),    8'(m_ret));
    check("model.lock_lost",  8'(lock_lost),  8'(m_lost));
    check("model.state",      8'(state_o),    8'(m_phase));
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are sampled at the falling edge.
  task automatic cycle(input logic r, input logic l, input logic s);
    rst_n        = r;
    pll_locked   = l;
    soft_rst_req = s;
    @(posedge clk);
    model_step(r, l, s);
    cyc++;
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int n, input logic r, input logic l, input logic s);
    for (int k = 0; k < n; k++) cycle(r, l, s);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         n;
    logic       r, l, s;
    logic       pr, f, c, run;
    logic [3:0] ret;
    logic       lost;
    pll_state_t st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic l, input logic s,
                     input logic pr, input logic f, input logic c, input logic rn,
                     input logic [3:0] ret, input logic lost, input pll_state_t st);
    vec_t v;
    v.n = n; v.r = r; v.l = l; v.s = s;
    v.pr = pr; v.f = f; v.c = c; v.run = rn;
    v.ret = ret; v.lost = lost; v.st = st;
    tbl.push_back(v);
  endtask

  logic lk, rr, ss_v;

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; soft_rst_req = 1'b0;
    m_phase = PLL_RST; m_age = 0; m_ret = 0; m_lost = 1'b0;
    model_reset_hist();

    //   n   r  l  s   pr f  c  run ret lost state
    // clean lock after reset
    add( 2, 0, 0, 0,  1, 0, 0, 0,  0, 0, PLL_RST);
    add( 3, 1, 0, 0,  1, 0, 0, 0,  0, 0, PLL_RST);
    add( 1, 1, 0, 0,  0, 0, 0, 0,  0, 0, WAIT_LOCK);
    add( 5, 1, 0, 0,  0, 0, 0, 0,  0, 0, WAIT_LOCK);
    add(10, 1, 1, 0,  0, 0, 0, 0,  0, 0, STABLE);
    add( 1, 1, 1, 0,  0, 1, 0, 0,  0, 0, RELEASE);
    add( 2, 1, 1, 0,  0, 1, 0, 0,  0, 0, RELEASE);
    add( 1, 1, 1, 0,  0, 1, 1, 1,  0, 0, RUN);
    add( 3, 1, 1, 0,  0, 1, 1, 1,  0, 0, RUN);
    // soft reset in RUN
    add( 1, 1, 1, 1,  0, 0, 0, 0,  0, 0, STABLE);
    add( 7, 1, 1, 0,  0, 0, 0, 0,  0, 0, STABLE);
    add( 1, 1, 1, 0,  0, 1, 0, 0,  0, 0, RELEASE);
    add( 2, 1, 1, 0,  0, 1, 0, 0,  0, 0, RELEASE);
    add( 1, 1, 1, 0,  0, 1, 1, 1,  0, 0, RUN);
    // soft reset on the same cycle as synchronised lock loss
    add( 2, 1, 0, 0,  0, 1, 1, 1,  0, 0, RUN);
    add( 1, 1, 0, 1,  0, 0, 0, 0,  0, 1, WAIT_LOCK);
    // relock: lock_lost stays set
    add( 3, 1, 1, 0,  0, 0, 0, 0,  0, 1, STABLE);
    add( 8, 1, 1, 0,  0, 1, 0, 0,  0, 1, RELEASE);
    add( 3, 1, 1, 0,  0, 1, 1, 1,  0, 1, RUN);
    // loss in RUN: resets drop three cycles later, no PLL reset
    add( 2, 1, 0, 0,  0, 1, 1, 1,  0, 1, RUN);
    add( 1, 1, 0, 0,  0, 0, 0, 0,  0, 1, WAIT_LOCK);
    add( 5, 1, 0, 0,  0, 0, 0, 0,  0, 1, WAIT_LOCK);
    // rst_n in the middle of RELEASE
    add(11, 1, 1, 0,  0, 1, 0, 0,  0, 1, RELEASE);
    add( 1, 0, 1, 0,  1, 0, 0, 0,  0, 0, PLL_RST);
    // glitch during STABLE after 5 stable cycles
    add( 3, 1, 1, 0,  1, 0, 0, 0,  0, 0, PLL_RST);
    add( 1, 1, 1, 0,  0, 0, 0, 0,  0, 0, WAIT_LOCK);
    add( 1, 1, 1, 0,  0, 0, 0, 0,  0, 0, STABLE);
    add( 4, 1, 1, 0,  0, 0, 0, 0,  0, 0, STABLE);
    add( 1, 1, 0, 0,  0, 0, 0, 0,  0, 0, STABLE);
    add( 1, 1, 1, 0,  0, 0, 0, 0,  0, 0, STABLE);
    add( 1, 1, 1, 0,  0, 0, 0, 0,  0, 0, WAIT_LOCK);
    add( 1, 1, 1, 0,  0, 0, 0, 0,  0, 0, STABLE);
    add( 7, 1, 1, 0,  0, 0, 0, 0,  0, 0, STABLE);
    add( 1, 1, 1, 0,  0, 1, 0, 0,  0, 0, RELEASE);
    // lock timeout: one full retry period
    add( 1, 0, 0, 0,  1, 0, 0, 0,  0, 0, PLL_RST);
    add( 4, 1, 0, 0,  0, 0, 0, 0,  0, 0, WAIT_LOCK);
    add(31, 1, 0, 0,  0, 0, 0, 0,  0, 0, WAIT_LOCK);
    add( 1, 1, 0, 0,  1, 0, 0, 0,  1, 0, PLL_RST);
    add( 3, 1, 0, 0,  1, 0, 0, 0,  1, 0, PLL_RST);
    add( 1, 1, 0, 0,  0, 0, 0, 0,  1, 0, WAIT_LOCK);

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i].n, tbl[i].r, tbl[i].l, tbl[i].s);
      check($sformatf("row%0d.pll_rst", i),    8'(pll_rst),    8'(tbl[i].pr));
      check($sformatf("row%0d.rst_fast_n", i), 8'(rst_fast_n), 8'(tbl[i].f));
      check($sformatf("row%0d.rst_core_n", i), 8'(rst_core_n), 8'(tbl[i].c));
      check($sformatf("row%0d.running", i),    8'(running),    8'(tbl[i].run));
      check($sformatf("row%0d.retries", i),    8'(retries),    8'(tbl[i].ret));
      check($sformatf("row%0d.lock_lost", i),  8'(lock_lost),  8'(tbl[i].lost));
      check($sformatf("row%0d.state", i),      8'(state_o),    8'(tbl[i].st));
    end

    // Lock seen on the exact timeout cycle: lock wins, no retry counted.
    run(29, 1, 0, 0);
    run(2, 1, 1, 0);
    check("boundary.pre_state", 8'(state_o), 8'(WAIT_LOCK));
    run(1, 1, 1, 0);
    check("boundary.state",   8'(state_o), 8'(STABLE));
    check("boundary.retries", 8'(retries), 8'd1);
    check("boundary.pll_rst", 8'(pll_rst), 8'd0);

    // Back to WAIT_LOCK, then keep timing out until retries saturates.
    run(3, 1, 0, 0);
    check("drop.state", 8'(state_o), 8'(WAIT_LOCK));
    for (int i = 2; i <= 17; i++) begin
      run((i == 2) ? LT : LT + PRC, 1, 0, 0);
      check($sformatf("retry%0d.pll_rst", i), 8'(pll_rst), 8'd1);
      check($sformatf("retry%0d.retries", i), 8'(retries), 8'((i > RETRY_MAX) ? RETRY_MAX : i));
      check($sformatf("retry%0d.rst_fast_n", i), 8'(rst_fast_n), 8'd0);
    end

    // Randomized stimulus, checked every cycle by the model.
    run(2, 0, 0, 0);
    lk = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rr   = ($urandom_range(0, 399) != 0);
      if (lk) lk = ($urandom_range(0, 59) != 0);
      else    lk = ($urandom_range(0, 24) == 0);
      ss_v = ($urandom_range(0, 39) == 0);
      cycle(rr, lk, ss_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
